muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit signed/unsigned multiply and divide unit with HI/LO result registers
//
// Ports:
//   clk      in   1  clock, all state updates on the rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  operation request, sampled only while idle
//   op       in   2  00 mult, 01 multu, 10 div, 11 divu
//   src_a    in  32  multiplicand / dividend
//   src_b    in  32  multiplier / divisor
//   busy     out  1  high whenever an operation is in flight
//   done     out  1  one-cycle completion pulse
//   hi       out 32  HI register (product upper word / remainder)
//   lo       out 32  LO register (product lower word / quotient)
//   div_zero out  1  set with done when a divide had a zero divisor

module muldiv_unit #(
  parameter int CALC_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam int CW = $clog2(CALC_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t         state;
  logic [1:0]     op_q;      // op[1]: divide, op[0]: unsigned
  logic [31:0]    opa;       // multiplicand (mult) / dividend (div) latched, then magnitude
  logic [31:0]    opb;       // multiplier (mult) / divisor (div) latched, then magnitude
  logic [63:0]    acc;       // mult: {partial product, multiplier}; div: low half shifts dividend out, quotient in
  logic [32:0]    rem;       // partial remainder, one bit wider than the divisor
  logic [CW-1:0]  cnt;
  logic           neg_res;   // negate product / quotient in FIX
  logic           neg_rem;   // negate remainder in FIX
  logic           dz;        // current operation is a divide by zero
  logic           dz_wait;   // one pad cycle so divide-by-zero completes at a fixed short latency

  logic           signed_op;
  logic           neg_a;
  logic           neg_b;
  logic [31:0]    mag_a;
  logic [31:0]    mag_b;
  logic [32:0]    mul_sum;
  logic [33:0]    trial;
  logic [63:0]    prod_fix;
  logic [31:0]    quo_fix;
  logic [31:0]    rem_fix;

  always_comb begin
    signed_op = ~op_q[0];
    neg_a     = signed_op & opa[31];
    neg_b     = signed_op & opb[31];
    // Magnitude of 0x80000000 is 0x80000000 read as unsigned, which is exactly right.
    mag_a     = neg_a ? (~opa + 32'd1) : opa;
    mag_b     = neg_b ? (~opb + 32'd1) : opb;

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set;
    // the carry becomes the new top bit after the right shift.
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opa : 32'd0)};

    // Restoring step: shifted remainder is below 2^33, so a 34-bit difference keeps the borrow in bit 33.
    trial     = {rem, acc[31]} - {2'b00, opb};

    prod_fix  = neg_res ? (~acc + 64'd1) : acc;
    quo_fix   = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix   = neg_rem ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      op_q     <= 2'd0;
      opa      <= 32'd0;
      opb      <= 32'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      dz_wait  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            opa      <= src_a;
            opb      <= src_b;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end

        PREP: begin
          cnt     <= '0;
          rem     <= 33'd0;
          opa     <= mag_a;
          opb     <= mag_b;
          neg_res <= neg_a ^ neg_b;
          neg_rem <= neg_a;
          acc     <= op_q[1] ? {32'd0, mag_a} : {32'd0, mag_b};
          if (op_q[1] && (opb == 32'd0)) begin
            dz      <= 1'b1;
            dz_wait <= 1'b1;
            state   <= FIX;
          end else begin
            dz      <= 1'b0;
            state   <= CALC;
          end
        end

        CALC: begin
          if (op_q[1]) begin
            if (!trial[33]) begin
              rem <= trial[32:0];
            end else begin
              rem <= {rem[31:0], acc[31]};
            end
            acc[31:0] <= {acc[30:0], ~trial[33]};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dz_wait) begin
            dz_wait <= 1'b0;
          end else begin
            if (dz) begin
              // HI/LO deliberately keep their previous contents.
              div_zero <= 1'b1;
            end else if (op_q[1]) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
//
// Ports: none (top-level bench).

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.CALC_CYCLES(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [31:0] h, logic [31:0] l, logic z, int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = z; e.lat = lat;
    return e;
  endfunction

  // Reference model: native 64-bit arithmetic, truncating division.
  function automatic exp_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    exp_t            e;
    longint          sp;
    longint unsigned up;
    int              q;
    int              r;
    e = mk(m_hi, m_lo, 1'b0, 34);
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32]; e.lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.dz = 1'b1; e.lat = 3;
        end else if (o == 2'b11) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.lo = q; e.hi = r;
        end
      end
    endcase
    return e;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    sb.push_back(e);
    m_hi  = e.hi;
    m_lo  = e.lo;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs so a design that fails to latch operands is caught.
    op    = 2'($urandom_range(0, 3));
    src_a = $urandom;
    src_b = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    check("dz_cleared_on_start", 64'(div_zero), 64'd0);
  endtask

  task automatic wait_result(input int pre);
    int          cyc = pre;
    bit          stable = 1'b1;
    bit          busy_ok = 1'b1;
    logic [31:0] h0 = hi;
    logic [31:0] l0 = lo;
    exp_t        e;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (!done) begin
        if (hi !== h0 || lo !== l0) stable = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    if (!done) begin
      check("done_timeout", 64'(done), 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("hi", 64'(hi), 64'(e.hi));
    check("lo", 64'(lo), 64'(e.lo));
    check("div_zero", 64'(div_zero), 64'(e.dz));
    check("busy_at_done", 64'(busy), 64'd0);
    check("hilo_stable", 64'(stable), 64'd1);
    check("busy_during", 64'(busy_ok), 64'd1);
  endtask

  initial begin
    exp_t        e;
    bit          saw;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    // Signed multiply with negative operand, fixed latency.
    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34));
    wait_result(0);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);

    launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34));
    wait_result(0);

    // Signed divide, then unsigned divide started in the done cycle.
    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34));
    wait_result(0);
    launch(2'b11, 32'hDDDD_DDDD, 32'h0000_0010, mk(32'h0000_000D, 32'h0DDD_DDDD, 1'b0, 34));
    wait_result(0);

    // Establish hi=1, lo=2, then divide by zero must leave them untouched.
    launch(2'b01, 32'h8000_0001, 32'h0000_0002, mk(32'h0000_0001, 32'h0000_0002, 1'b0, 34));
    wait_result(0);
    launch(2'b11, 32'h1234_5678, 32'h0000_0000, mk(32'h0000_0001, 32'h0000_0002, 1'b1, 3));
    wait_result(0);
    launch(2'b00, 32'h0000_0005, 32'h0000_0006, mk(32'h0000_0000, 32'h0000_001E, 1'b0, 34));
    wait_result(0);

    // A second start mid-CALC is ignored.
    e = model(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    launch(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, e);
    repeat (5) tick();
    op = 2'b10; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_result(6);

    // Reset ten cycles into a multiply, with a start in the reset cycle.
    e = model(2'b00, 32'h0000_1234, 32'h0000_5678);
    launch(2'b00, 32'h0000_1234, 32'h0000_5678, e);
    repeat (9) tick();
    rst = 1'b1; start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_div_zero", 64'(div_zero), 64'd0);
    void'(sb.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst = 1'b0; start = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    check("no_activity_after_abort", 64'(saw), 64'd0);

    // Clean operation after the abort.
    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34));
    wait_result(0);

    // Most-negative dividend over -1.
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0000_0000, 32'h8000_0000, 1'b0, 34));
    wait_result(0);

    // Random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 3) b = 32'd0;
      if (i % 5 == 1) b = 32'($urandom_range(1, 20));
      e = model(o, a, b);
      launch(o, a, b, e);
      wait_result(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
